window_mac: RTL
===============

WINDOW_MAC -- requirements
Module: window_mac

Interface
REQ-001 Parameter PIX_W, default 8, unsigned pixel width.
REQ-002 Parameter W_W, default 8, signed two's-complement weight width.
REQ-003 Parameter ACC_W, default PIX_W+W_W+5, signed accumulator/result width; holds 25 full-scale products without overflow.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  run enable, same signal that drives the upstream address generator; low = idle and clear window progress.
REQ-007 pix_valid  input  1  pix carries one window pixel this cycle.
REQ-008 pix  input  PIX_W  pixel read from image memory at the generator address.
REQ-009 w_load  input  1  weight write strobe.
REQ-010 w_addr  input  5  tap index 0..24 = 5*(row)+(col), row/col 0-based.
REQ-011 w_data  input  W_W  signed weight value.
REQ-012 out_valid  output  1  one-cycle pulse, out_data holds a completed window sum.
REQ-013 out_data  output  ACC_W  signed 5x5 dot product, post-activation.
REQ-014 tap  output  5  index of next expected pixel in the current window, 0..24.

Function
REQ-015 Pixels arrive column-fastest, row-slowest, 25 per window; pixel k multiplies weight[k], k = tap at the pix_valid cycle.
REQ-016 tap increments on each pix_valid with start=1; wraps 24->0 on the 25th pixel with no dead cycle; next window may begin the following cycle.
REQ-017 pix_valid low: tap, accumulator and pipeline hold; gaps of any length are legal.
REQ-018 Two-stage pipeline: stage 1 registers signed product pix*weight[tap] with first/last flags; stage 2 loads (first) or adds (otherwise) into accumulator.
REQ-019 Latency: 25th pix_valid sampled at edge t -> out_valid high and out_data valid in the cycle after edge t+2.
REQ-020 out_valid high for exactly one cycle per completed window; out_data holds its value until the next completed window.
REQ-021 Product sign-extended to ACC_W before accumulation; pix zero-extended (unsigned) before multiply; no saturation needed.
REQ-022 Weight file: 25 x W_W registers; written when w_load=1 and start=0; w_addr>24 ignored; writes with start=1 ignored.
REQ-023 FSM states IDLE (start=0) and RUN (start=1); IDLE->RUN on start rising, RUN->IDLE on start falling.
REQ-024 Entering IDLE: tap<=0, pipeline valid/flags cleared, partial sum discarded, no out_valid for the aborted window; out_data retains last value.
REQ-025 pix_valid while start=0 ignored.

Reset
REQ-026 reset=1 at an edge: tap=0, out_valid=0, out_data=0, accumulator=0, pipeline flags cleared, all weights=0, FSM=IDLE; overrides all inputs including mid-window.

Configuration
REQ-027 Macro WINDOW_MAC_RELU_EN defined: out_data = 0 when completed sum negative, else sum.
REQ-028 WINDOW_MAC_RELU_EN undefined: out_data = raw signed sum; timing identical in both builds.

Verification
REQ-029 All weights 1, start=1, pix 1..25 on consecutive cycles -> single out_valid two cycles after 25th pixel, out_data=325.
REQ-030 All weights -1, 25 pixels of 255 -> out_data=-6375 (raw build); 0 with WINDOW_MAC_RELU_EN.
REQ-031 Weights 1, 50 back-to-back pixels (1..25 then 25 x 2) -> out_valid pulses 25 cycles apart with 325 then 50; tap wraps 24->0.
REQ-032 Weights 1, start dropped after 10 pixels, re-raised, 25 pixels of 3 -> exactly one out_valid, out_data=75.
REQ-033 Weights 1, 25 pixels of 4 with pix_valid toggling every other cycle -> out_data=100, out_valid two cycles after last pixel.
REQ-034 w_load with start=1 (w_addr 0, w_data 5) then window of 1s -> out_data=25; reset asserted mid-window -> weights 0, out_data=0, tap=0, no out_valid.

Source files
------------

// File: rtl/window_mac.sv
// 5x5 window multiply-accumulate: unsigned pixels times signed weights; the window's dot product goes to out_data.
// Latency: 25th pixel sampled at edge t gives an out_valid pulse after edge t+2. No backpressure; pix_valid gaps hold state.
// Optional build macro WINDOW_MAC_RELU_EN clamps negative window sums to zero.
module window_mac #(
    parameter int PIX_W = 8,
    parameter int W_W   = 8,
    parameter int ACC_W = PIX_W + W_W + 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    pix_valid,
    input  logic [PIX_W-1:0]        pix,
    input  logic                    w_load,
    input  logic [4:0]              w_addr,
    input  logic signed [W_W-1:0]   w_data,
    output logic                    out_valid,
    output logic signed [ACC_W-1:0] out_data,
    output logic [4:0]              tap
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state;
    logic signed [W_W-1:0]   weights [25];
    logic signed [ACC_W-1:0] s1_prod;
    logic                    s1_vld;
    logic                    s1_first;
    logic                    s1_last;
    logic signed [ACC_W-1:0] acc;
    logic                    acc_done;

    logic signed [ACC_W-1:0] pix_ext;
    logic signed [ACC_W-1:0] w_ext;
    logic signed [ACC_W-1:0] prod;
    logic signed [ACC_W-1:0] act;

    // Both operands widened to ACC_W first; the true product always fits, so truncation is exact.
    assign pix_ext = {{(ACC_W-PIX_W){1'b0}}, pix};
    assign w_ext   = {{(ACC_W-W_W){weights[tap][W_W-1]}}, weights[tap]};
    assign prod    = pix_ext * w_ext;

`ifdef WINDOW_MAC_RELU_EN
    assign act = acc[ACC_W-1] ? '0 : acc;
`else
    assign act = acc;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            tap       <= '0;
            s1_prod   <= '0;
            s1_vld    <= 1'b0;
            s1_first  <= 1'b0;
            s1_last   <= 1'b0;
            acc       <= '0;
            acc_done  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            for (int i = 0; i < 25; i++) weights[i] <= '0;
        end else begin
            state <= start ? RUN : IDLE;

            if (w_load && !start && (w_addr < 5'd25))
                weights[w_addr] <= w_data;

            if (start) begin
                s1_vld <= pix_valid;
                if (pix_valid) begin
                    s1_prod  <= prod;
                    s1_first <= (tap == 5'd0);
                    s1_last  <= (tap == 5'd24);
                    tap      <= (tap == 5'd24) ? 5'd0 : tap + 5'd1;
                end

                // Accumulator only moves on a valid product; the done flag still drains through gaps.
                if (s1_vld)
                    acc <= s1_first ? s1_prod : acc + s1_prod;
                acc_done  <= s1_vld && s1_last;
                out_valid <= acc_done;
                if (acc_done)
                    out_data <= act;
            end else if (state == RUN) begin
                // Abort: drop the partial window; out_data keeps the last completed result.
                tap       <= '0;
                s1_vld    <= 1'b0;
                s1_first  <= 1'b0;
                s1_last   <= 1'b0;
                acc       <= '0;
                acc_done  <= 1'b0;
                out_valid <= 1'b0;
            end
        end
    end

endmodule
